// File: rtl/float_copro_seq.sv
// Command sequencer for the float coprocessor: 4-entry register file, dispatch of
// MUL / ADD / SUB to external units over start/done, one response per command.
module float_copro_seq #(
  parameter int FW      = 32,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [1:0]    cmd_rd,
  input  logic [1:0]    cmd_ra,
  input  logic [1:0]    cmd_rb,
  input  logic [FW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [FW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          mul_start,
  output logic [FW-1:0] mul_a,
  output logic [FW-1:0] mul_b,
  input  logic          mul_done,
  input  logic [FW-1:0] mul_res,
  output logic          add_start,
  output logic [FW-1:0] add_a,
  output logic [FW-1:0] add_b,
  output logic          add_sub,
  input  logic          add_done,
  input  logic [FW-1:0] add_res,
  output logic          busy
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, ADD_WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] regs [4];
  logic [1:0]    rd_q;
  logic [TW-1:0] tcnt;
  logic          accept, waiting, unit_done, tmo;
  logic [FW-1:0] unit_res;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && (state == IDLE);
  assign waiting   = (state == MUL_WAIT) || (state == ADD_WAIT);
  // Only the unit that was dispatched can end the wait; the other unit's done is ignored.
  assign unit_done = ((state == MUL_WAIT) && mul_done) || ((state == ADD_WAIT) && add_done);
  assign unit_res  = (state == MUL_WAIT) ? mul_res : add_res;
  assign tmo       = waiting && !unit_done && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_MUL:         state_nxt = MUL_WAIT;
            OP_ADD, OP_SUB: state_nxt = ADD_WAIT;
            default:        state_nxt = RESP;
          endcase
        end
      end
      MUL_WAIT, ADD_WAIT: if (unit_done || tmo) state_nxt = RESP;
      RESP:               if (rsp_ready) state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_sub   <= 1'b0;
      mul_start <= 1'b0;
      add_start <= 1'b0;
      tcnt      <= '0;
      rd_q      <= '0;
    end else begin
      // Start pulses are high only in the first wait cycle.
      mul_start <= accept && (cmd_op == OP_MUL);
      add_start <= accept && ((cmd_op == OP_ADD) || (cmd_op == OP_SUB));
      if (accept) begin
        rd_q    <= cmd_rd;
        tcnt    <= '0;
        rsp_err <= 1'b0;
        case (cmd_op)
          OP_LOAD: begin
            regs[cmd_rd] <= cmd_data;
            rsp_data     <= cmd_data;
          end
          OP_STORE: rsp_data <= regs[cmd_ra];
          OP_NOP:   rsp_data <= '0;
          OP_MUL: begin
            mul_a <= regs[cmd_ra];
            mul_b <= regs[cmd_rb];
          end
          OP_ADD, OP_SUB: begin
            add_a   <= regs[cmd_ra];
            add_b   <= regs[cmd_rb];
            add_sub <= (cmd_op == OP_SUB);
          end
          default: begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end
        endcase
      end else if (waiting) begin
        if (unit_done) begin
          regs[rd_q] <= unit_res;
          rsp_data   <= unit_res;
          rsp_err    <= 1'b0;
        end else begin
          tcnt <= tcnt + TW'(1);
          if (tmo) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end
        end
      end else if ((state == RESP) && rsp_ready) begin
        rsp_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_float_copro_seq.sv
// Bench for float_copro_seq: directed and random commands against a register-file
// model; the bench also plays the multiplier and add/sub units.
module tb_float_copro_seq;
  localparam int FW      = 32;
  localparam int TIMEOUT = 64;
  localparam int TW      = 7;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [1:0]    cmd_rd, cmd_ra, cmd_rb;
  logic [FW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [FW-1:0] rsp_data;
  logic          mul_start, mul_done, add_start, add_done, add_sub, busy;
  logic [FW-1:0] mul_a, mul_b, mul_res, add_a, add_b, add_res;

  float_copro_seq #(.FW(FW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_res(mul_res),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_done(add_done), .add_res(add_res), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] mregs [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // dly: wait cycle (1 = start cycle) on which the unit answers; 0 = never answers.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [31:0] data, input logic [31:0] res,
                       input int dly, input int hold);
    int cyc, starts_m, starts_a, exp_lat;
    logic [31:0] exp_data, held;
    logic exp_err;
    bit is_mul, is_add;
    is_mul = (op == 3'd2);
    is_add = (op == 3'd3) || (op == 3'd4);
    starts_m = 0;
    starts_a = 0;
    exp_err  = 1'b0;
    exp_lat  = 1;
    case (op)
      3'd0: exp_data = 32'h0;
      3'd1: exp_data = data;
      3'd5: exp_data = mregs[ra];
      3'd2, 3'd3, 3'd4: begin
        if (dly > 0) begin exp_data = res; exp_lat = dly + 1; end
        else begin exp_data = 32'h0; exp_err = 1'b1; exp_lat = TIMEOUT + 1; end
      end
      default: begin exp_data = 32'h0; exp_err = 1'b1; end
    endcase

    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc <= TIMEOUT + 4) begin
      if (mul_start) begin
        starts_m++;
        chk("mul_a", mul_a, mregs[ra]);
        chk("mul_b", mul_b, mregs[rb]);
      end
      if (add_start) begin
        starts_a++;
        chk("add_a", add_a, mregs[ra]);
        chk("add_b", add_b, mregs[rb]);
        chk("add_sub", add_sub, (op == 3'd4));
      end
      mul_res  = res;
      add_res  = res;
      mul_done = is_mul && (cyc == dly);
      add_done = is_add && (cyc == dly);
      if (cyc == 1 && dly != 1) begin
        if (is_mul) begin add_done = 1'b1; add_res = ~res; end
        if (is_add) begin mul_done = 1'b1; mul_res = ~res; end
      end
      @(negedge clk);
      cyc++;
    end
    mul_done = 1'b0;
    add_done = 1'b0;
    chk("latency", cyc, exp_lat);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, exp_err);
    chk("mul_starts", starts_m, is_mul);
    chk("add_starts", starts_a, is_add);
    chk("no_start_in_resp", {mul_start, add_start}, 2'b00);

    if (op == 3'd1) mregs[rd] = data;
    if ((is_mul || is_add) && dly > 0) mregs[rd] = res;

    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = $urandom;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_data", rsp_data, held);
      chk("hold_ready", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", rsp_valid, 1'b0);
    chk("rsp_done_err", rsp_err, 1'b0);
    chk("rsp_done_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_data = '0; rsp_ready = 1'b0; mul_done = 1'b0; mul_res = '0; add_done = 1'b0; add_res = '0;
    for (int i = 0; i < 4; i++) mregs[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_starts", {mul_start, add_start, add_sub, rsp_err}, 4'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_operands", mul_a | mul_b | add_a | add_b, 32'h0);
    reset_n = 1'b1;

    issue(3'd1, 2'd0, 2'd0, 2'd0, 32'h4000_0000, 32'h0, 0, 0);
    issue(3'd1, 2'd1, 2'd0, 2'd0, 32'h4040_0000, 32'h0, 0, 0);
    issue(3'd2, 2'd2, 2'd0, 2'd1, 32'h0, 32'h40C0_0000, 2, 0);
    issue(3'd5, 2'd0, 2'd2, 2'd0, 32'h0, 32'h0, 0, 0);
    chk("store_mul_result", rsp_data, 32'h40C0_0000);
    issue(3'd4, 2'd3, 2'd1, 2'd0, 32'h0, 32'h3F80_0000, 1, 0);
    issue(3'd5, 2'd0, 2'd3, 2'd0, 32'h0, 32'h0, 0, 0);

    issue(3'd2, 2'd2, 2'd0, 2'd1, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    mul_done = 1'b1; mul_res = 32'hDEAD_BEEF;
    @(negedge clk);
    mul_done = 1'b0;
    chk("stray_done_rsp", rsp_valid, 1'b0);
    chk("stray_done_busy", busy, 1'b0);
    issue(3'd5, 2'd0, 2'd2, 2'd0, 32'h0, 32'h0, 0, 0);
    chk("timeout_keeps_reg", rsp_data, 32'h40C0_0000);

    issue(3'd7, 2'd1, 2'd0, 2'd0, 32'h1234_5678, 32'h0, 0, 0);
    issue(3'd6, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0, 0, 0);
    for (int r = 0; r < 4; r++) issue(3'd5, 2'd0, 2'(r), 2'd0, 32'h0, 32'h0, 0, 0);
    issue(3'd5, 2'd0, 2'd1, 2'd0, 32'h0, 32'h0, 0, 10);
    issue(3'd3, 2'd1, 2'd0, 2'd1, 32'h0, 32'h4120_0000, TIMEOUT, 0);
    issue(3'd3, 2'd0, 2'd0, 2'd0, 32'h0, 32'h4130_0000, TIMEOUT - 1, 0);
    issue(3'd0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0, 0, 1);

    for (int n = 0; n < 40; n++)
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(1, 6),
            $urandom_range(0, 3));
    for (int r = 0; r < 4; r++) issue(3'd5, 2'd0, 2'(r), 2'd0, 32'h0, 32'h0, 0, 0);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_rd = 2'd1; cmd_ra = 2'd0; cmd_rb = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_reset_busy", busy, 1'b0);
    chk("mid_reset_ready", cmd_ready, 1'b1);
    chk("mid_reset_ops", mul_a | mul_b, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    mul_done = 1'b1; mul_res = 32'hCAFE_F00D;
    @(negedge clk);
    mul_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_done_ignored", rsp_valid, 1'b0);
    for (int i = 0; i < 4; i++) mregs[i] = 32'h0;
    for (int r = 0; r < 4; r++) issue(3'd5, 2'd0, 2'(r), 2'd0, 32'h0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
